// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair: the checker state type and the
// XNOR Fibonacci feedback function (xapp052 taps), so both ends always use the same polynomial.
package lfsr_pkg;

    localparam int LFSR_N_MAX = 32;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Tap k of the xapp052 table is register bit k-1; the word shifts towards the MSB.
    function automatic logic lfsr_fb(input int n, input logic [31:0] s);
        logic x;
        case (n)
            3:       x = s[2]  ^ s[1];
            4:       x = s[3]  ^ s[2];
            5:       x = s[4]  ^ s[2];
            6:       x = s[5]  ^ s[4];
            7:       x = s[6]  ^ s[5];
            8:       x = s[7]  ^ s[5]  ^ s[4]  ^ s[3];
            9:       x = s[8]  ^ s[4];
            10:      x = s[9]  ^ s[6];
            11:      x = s[10] ^ s[8];
            12:      x = s[11] ^ s[5]  ^ s[3]  ^ s[0];
            13:      x = s[12] ^ s[3]  ^ s[2]  ^ s[0];
            14:      x = s[13] ^ s[4]  ^ s[2]  ^ s[0];
            15:      x = s[14] ^ s[13];
            16:      x = s[15] ^ s[14] ^ s[12] ^ s[3];
            17:      x = s[16] ^ s[13];
            18:      x = s[17] ^ s[10];
            19:      x = s[18] ^ s[5]  ^ s[1]  ^ s[0];
            20:      x = s[19] ^ s[16];
            21:      x = s[20] ^ s[18];
            22:      x = s[21] ^ s[20];
            23:      x = s[22] ^ s[17];
            24:      x = s[23] ^ s[22] ^ s[21] ^ s[16];
            25:      x = s[24] ^ s[21];
            26:      x = s[25] ^ s[5]  ^ s[1]  ^ s[0];
            27:      x = s[26] ^ s[4]  ^ s[1]  ^ s[0];
            28:      x = s[27] ^ s[24];
            29:      x = s[28] ^ s[26];
            30:      x = s[29] ^ s[5]  ^ s[3]  ^ s[0];
            31:      x = s[30] ^ s[27];
            32:      x = s[31] ^ s[21] ^ s[1]  ^ s[0];
            default: x = 1'b0;
        endcase
        return ~x;
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-word predictor: the word the generator emits after prev.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] prev,
    output logic [N-1:0] pred
);

    logic [LFSR_N_MAX-1:0] prev_ext;

    assign prev_ext = LFSR_N_MAX'(prev);
    assign pred     = {prev[N-2:0], lfsr_fb(N, prev_ext)};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for lock on the incoming LFSR stream, then flags and
// counts mismatching words, flywheeling through isolated errors and dropping lock on a burst.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int N          = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [N-1:0]     data_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] UNLOCK_LAST = MISS_W'(UNLOCK_CNT - 1);

    generate
        if (N < 3 || N > LFSR_N_MAX) begin : g_bad_n
            $error("prbs_checker: N must be in 3..32");
        end
    endgenerate

    state_e              state;
    logic                has_prev;
    logic [N-1:0]        prev;
    logic [N-1:0]        pred;
    logic [RUN_W-1:0]    run;
    logic [MISS_W-1:0]   miss;
    logic                match;
    logic                all_ones;

    lfsr_predict #(.N(N)) u_predict (
        .prev (prev),
        .pred (pred)
    );

    assign match    = (data_i == pred);
    assign all_ones = &data_i;

    // History register: reseeded from the line except on a LOCKED miss, where it flywheels on pred.
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            prev <= (state == LOCKED && !match) ? pred : data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= HUNT;
            has_prev  <= 1'b0;
            run       <= '0;
            miss      <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                unique case (state)
                    HUNT: begin
                        if (!has_prev) begin
                            has_prev <= 1'b1;
                            run      <= '0;
                        end else if (match && !all_ones) begin
                            if (run == LOCK_LAST) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                run      <= '0;
                                miss     <= '0;
                            end else begin
                                run <= run + 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss <= '0;
                        end else begin
                            err_o <= 1'b1;
                            if (err_cnt_o != '1) begin
                                err_cnt_o <= err_cnt_o + 1'b1;
                            end
                            if (miss == UNLOCK_LAST) begin
                                state    <= HUNT;
                                locked_o <= 1'b0;
                                has_prev <= 1'b0;
                                miss     <= '0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Clear takes priority over an increment in the same cycle.
            if (clr_i) begin
                err_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker at N=8 using a hand-derived table of the generator stream.
module tb_prbs_checker;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       clr;
    logic       locked;
    logic       err;
    logic [3:0] cnt;

    int checks = 0;
    int errors = 0;

    // XNOR LFSR, taps 8,6,5,4, shifted left from 0x00.
    logic [7:0] S [0:20] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A,
                             8'hF4, 8'hE8, 8'hD0, 8'hA1, 8'h43, 8'h87, 8'h0E, 8'h1C,
                             8'h39, 8'h72, 8'hE5, 8'hCB, 8'h97};

    prbs_checker #(.N(8), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .data_i    (data),
        .clr_i     (clr),
        .locked_o  (locked),
        .err_o     (err),
        .err_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        valid = v;
        data  = d;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", cnt); end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, S[i], 1'b0);
            checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL lock_locked beat %0d got %b want %b", i, locked, (i == 4)); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_err beat %0d got %b want 0", i, err); end
        end
    endtask

    task automatic test_single_error();
        logic [7:0] bad;
        step(1'b1, S[5], 1'b0);
        checks++; if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL single_pre got err=%b locked=%b want 0/1", err, locked); end
        bad = S[6] ^ 8'h01;
        step(1'b1, bad, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_err got %b want 1", err); end
        checks++; if (cnt !== 4'h1) begin errors++; $display("FAIL single_cnt got %h want 1", cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", locked); end
        step(1'b1, S[7], 1'b0);
        checks++; if (err !== 1'b0 || cnt !== 4'h1 || locked !== 1'b1) begin errors++; $display("FAIL single_recover got err=%b cnt=%h locked=%b want 0/1/1", err, cnt, locked); end
        step(1'b1, S[8], 1'b0);
        checks++; if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL single_follow got err=%b locked=%b want 0/1", err, locked); end
    endtask

    task automatic test_unlock();
        step(1'b0, 8'h00, 1'b1);
        checks++; if (cnt !== 4'h0) begin errors++; $display("FAIL unlock_clr got %h want 0", cnt); end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'hAA, 1'b0);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL unlock_err miss %0d got %b want 1", k, err); end
            checks++; if (cnt !== 4'(k + 1)) begin errors++; $display("FAIL unlock_cnt miss %0d got %h want %h", k, cnt, 4'(k + 1)); end
            checks++; if (locked !== (k < 3)) begin errors++; $display("FAIL unlock_locked miss %0d got %b want %b", k, locked, (k < 3)); end
        end
        for (int i = 13; i < 18; i++) begin
            step(1'b1, S[i], 1'b0);
            checks++; if (locked !== (i == 17) || err !== 1'b0) begin errors++; $display("FAIL relock beat %0d got locked=%b err=%b want %b/0", i, locked, err, (i == 17)); end
        end
    endtask

    task automatic test_gaps();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, S[i], 1'b0);
            checks++; if (locked !== (i == 4) || err !== 1'b0) begin errors++; $display("FAIL gaps_beat %0d got locked=%b err=%b want %b/0", i, locked, err, (i == 4)); end
            step(1'b0, 8'hFF, 1'b0);
            checks++; if (locked !== (i == 4) || err !== 1'b0) begin errors++; $display("FAIL gaps_idle %0d got locked=%b err=%b want %b/0", i, locked, err, (i == 4)); end
        end
    endtask

    task automatic test_sat_clear();
        logic [3:0] want;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) step(1'b1, 8'hAA, 1'b0);
            want = (4 * (b + 1) > 15) ? 4'hF : 4'(4 * (b + 1));
            checks++; if (cnt !== want) begin errors++; $display("FAIL sat_cnt burst %0d got %h want %h", b, cnt, want); end
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sat_unlock burst %0d got %b want 0", b, locked); end
            for (int i = 0; i < 5; i++) step(1'b1, S[i], 1'b0);
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_relock burst %0d got %b want 1", b, locked); end
        end
        step(1'b1, 8'hAA, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_err got %b want 1", err); end
        checks++; if (cnt !== 4'h0) begin errors++; $display("FAIL clr_wins got %h want 0", cnt); end
        step(1'b1, 8'hAA, 1'b0);
        checks++; if (cnt !== 4'h1) begin errors++; $display("FAIL clr_then_inc got %h want 1", cnt); end
    endtask

    task automatic test_reset_lockup();
        rst = 1'b1;
        step(1'b1, 8'hAA, 1'b1);
        checks++; if (locked !== 1'b0 || err !== 1'b0 || cnt !== 4'h0) begin errors++; $display("FAIL midreset got locked=%b err=%b cnt=%h want 0/0/0", locked, err, cnt); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            checks++; if (locked !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL lockup beat %0d got locked=%b err=%b want 0/0", i, locked, err); end
        end
        checks++; if (cnt !== 4'h0) begin errors++; $display("FAIL lockup_cnt got %h want 0", cnt); end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        clr   = 1'b0;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_unlock();
        test_gaps();
        test_sat_clear();
        test_reset_lockup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
